// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants.
// Also used by the pipelined multiplier.
package mips_pkg;

  localparam int DATA_32_W  = 32;
  localparam int MULT_LAT_C = 4;

  typedef enum logic {
    HILO_IDLE,
    HILO_BUSY
  } hilo_state_t;

endpackage

// File: rtl/mips_hilo_scoreboard.sv
// In-flight multiply counter, busy FSM and sticky error flag.
// Build option MIPS_HILO_BYPASS_EN enables the last-result forward flag.
module mips_hilo_scoreboard
  import mips_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_C
) (
  input  logic clk,
  input  logic rst,
  input  logic mult_start,
  input  logic mult_done,
  input  logic conflict,
  output logic busy,
  output logic fwd,
  output logic err
);

  localparam int CW = $clog2(MULT_LAT + 1);
  localparam logic [CW-1:0] FULL = CW'(MULT_LAT);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          err_nxt;
  hilo_state_t   state;
  hilo_state_t   state_nxt;

  always_comb begin
    count_nxt = count;
    err_nxt   = err | conflict;
    unique case ({mult_start, mult_done})
      2'b10: begin
        if (count == FULL) err_nxt = 1'b1;
        else count_nxt = count + 1'b1;
      end
      2'b01: begin
        if (count == '0) err_nxt = 1'b1;
        else count_nxt = count - 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      HILO_IDLE:
        if (count_nxt != '0) state_nxt = HILO_BUSY;
      HILO_BUSY:
        if (count_nxt == '0) state_nxt = HILO_IDLE;
      default: state_nxt = HILO_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      err   <= 1'b0;
      state <= HILO_IDLE;
    end else begin
      count <= count_nxt;
      err   <= err_nxt;
      state <= state_nxt;
    end
  end

  assign busy = (state == HILO_BUSY);

  // The final outstanding result is on the bus right now.
`ifdef MIPS_HILO_BYPASS_EN
  assign fwd = (count == ONE) & mult_done;
`else
  assign fwd = 1'b0;
`endif

endmodule

// File: rtl/mips_hilo_unit.sv
// HI/LO register pair with multiply scoreboard and MFHI/MFLO stall.
// Build option MIPS_HILO_BYPASS_EN forwards the last product to reads.
module mips_hilo_unit
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_32_W,
  parameter int MULT_LAT = MULT_LAT_C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mult_start,
  input  logic              mult_done,
  input  logic [DATA_W-1:0] mult_lower,
  input  logic [DATA_W-1:0] mult_higher,
  input  logic              mthi_en,
  input  logic              mtlo_en,
  input  logic [DATA_W-1:0] mt_data,
  input  logic              mfhi_req,
  input  logic              mflo_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall,
  output logic              busy,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic              err
);

  logic              fwd;
  logic              conflict;
  logic              rd_req;
  logic [DATA_W-1:0] hi_nxt;
  logic [DATA_W-1:0] lo_nxt;
  logic [DATA_W-1:0] hi_src;
  logic [DATA_W-1:0] lo_src;

  assign conflict = mfhi_req & mflo_req;
  assign rd_req   = mfhi_req | mflo_req;

  mips_hilo_scoreboard #(
    .MULT_LAT(MULT_LAT)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .mult_start(mult_start),
    .mult_done (mult_done),
    .conflict  (conflict),
    .busy      (busy),
    .fwd       (fwd),
    .err       (err)
  );

  // Move-to beats the product per register.
  always_comb begin
    hi_nxt = hi_q;
    priority case (1'b1)
      mthi_en:   hi_nxt = mt_data;
      mult_done: hi_nxt = mult_higher;
      default: ;
    endcase
  end

  always_comb begin
    lo_nxt = lo_q;
    priority case (1'b1)
      mtlo_en:   lo_nxt = mt_data;
      mult_done: lo_nxt = mult_lower;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
    end
  end

  assign hi_src = fwd ? hi_nxt : hi_q;
  assign lo_src = fwd ? lo_nxt : lo_q;

  always_comb begin
    rd_data = '0;
    priority case (1'b1)
      mfhi_req: rd_data = hi_src;
      mflo_req: rd_data = lo_src;
      default: ;
    endcase
  end

  assign stall = rd_req & busy & ~fwd;

endmodule

// File: tb/tb_mips_hilo_unit.sv
// Scoreboard bench for mips_hilo_unit: reads are checked by a monitor
// that pops expected values whenever an unstalled MFHI/MFLO occurs.
module tb_mips_hilo_unit;

  logic        clk;
  logic        rst;
  logic        mult_start;
  logic        mult_done;
  logic [31:0] mult_lower;
  logic [31:0] mult_higher;
  logic        mthi_en;
  logic        mtlo_en;
  logic [31:0] mt_data;
  logic        mfhi_req;
  logic        mflo_req;
  logic [31:0] rd_data;
  logic        stall;
  logic        busy;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        err;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;
  int   stall_cnt;

`ifdef MIPS_HILO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  mips_hilo_unit dut (
    .clk        (clk),
    .rst        (rst),
    .mult_start (mult_start),
    .mult_done  (mult_done),
    .mult_lower (mult_lower),
    .mult_higher(mult_higher),
    .mthi_en    (mthi_en),
    .mtlo_en    (mtlo_en),
    .mt_data    (mt_data),
    .mfhi_req   (mfhi_req),
    .mflo_req   (mflo_req),
    .rd_data    (rd_data),
    .stall      (stall),
    .busy       (busy),
    .hi_q       (hi_q),
    .lo_q       (lo_q),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic push(string n, logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    q.push_back(e);
  endtask

  // Monitor: count stalls, compare every accepted read.
  always @(negedge clk) begin
    if (rst && stall) stall_cnt++;
    if (rst && (mfhi_req | mflo_req) && !stall) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %h expected none",
                 rd_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk(e.name, rd_data, e.val);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mult_start  = 1'b0;
    mult_done   = 1'b0;
    mult_lower  = '0;
    mult_higher = '0;
    mthi_en     = 1'b0;
    mtlo_en     = 1'b0;
    mt_data     = '0;
    mfhi_req    = 1'b0;
    mflo_req    = 1'b0;
  endtask

  task automatic done(logic [31:0] h, logic [31:0] l);
    mult_done   = 1'b1;
    mult_higher = h;
    mult_lower  = l;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    stall_cnt = 0;
    idle();
    rst = 1'b0;
    #3;
    chk("rst_hi", hi_q, 32'h0);
    chk("rst_lo", lo_q, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_rd", rd_data, 32'h0);
    rst = 1'b1;
    cyc();

    // Single multiply 7*9, MFLO held from c1.
    mult_start = 1'b1;
    cyc();
    mult_start = 1'b0;
    mflo_req   = 1'b1;
    stall_cnt  = 0;
    push("mul_lo", 32'd63);
    if (BYP) push("mul_lo_hold", 32'd63);
    @(negedge clk);
    chk("mul_busy_c1", {31'b0, busy}, 32'h1);
    cyc();
    cyc();
    cyc();
    done(32'h0, 32'd63);
    cyc();
    idle();
    mflo_req = 1'b1;
    cyc();
    idle();
    chk("mul_stalls", stall_cnt, BYP ? 32'd3 : 32'd4);
    chk("mul_lo_q", lo_q, 32'd63);
    chk("mul_hi_q", hi_q, 32'd0);
    chk("mul_busy_end", {31'b0, busy}, 32'h0);

    // Back-to-back starts, MFHI from c3.
    mult_start = 1'b1;
    cyc();
    cyc();
    cyc();
    mult_start = 1'b0;
    mfhi_req   = 1'b1;
    stall_cnt  = 0;
    if (BYP) push("b2b_hi_fwd", 32'h33);
    push("b2b_hi", 32'h33);
    cyc();
    done(32'h11, 32'h1);
    cyc();
    done(32'h22, 32'h2);
    cyc();
    done(32'h33, 32'h3);
    @(negedge clk);
    chk("b2b_busy_c6", {31'b0, busy}, 32'h1);
    cyc();
    idle();
    mfhi_req = 1'b1;
    @(negedge clk);
    chk("b2b_busy_c7", {31'b0, busy}, 32'h0);
    cyc();
    idle();
    chk("b2b_stalls", stall_cnt, BYP ? 32'd3 : 32'd4);
    chk("b2b_lo_q", lo_q, 32'h3);

    // MTHI collides with done.
    mult_start = 1'b1;
    cyc();
    idle();
    cyc();
    cyc();
    cyc();
    done(32'h1, 32'h2);
    mthi_en = 1'b1;
    mt_data = 32'hDEAD_BEEF;
    cyc();
    idle();
    chk("col_hi", hi_q, 32'hDEAD_BEEF);
    chk("col_lo", lo_q, 32'h2);
    chk("col_busy", {31'b0, busy}, 32'h0);
    mfhi_req = 1'b1;
    push("col_rd_hi", 32'hDEAD_BEEF);
    cyc();
    idle();

    // MTLO while busy, then done overwrites.
    mult_start = 1'b1;
    cyc();
    idle();
    mtlo_en = 1'b1;
    mt_data = 32'h55;
    cyc();
    idle();
    chk("mtlo_busy_lo", lo_q, 32'h55);
    chk("mtlo_busy", {31'b0, busy}, 32'h1);
    cyc();
    cyc();
    done(32'hBB, 32'hAA);
    cyc();
    idle();
    chk("mtlo_done_lo", lo_q, 32'hAA);
    chk("mtlo_done_hi", hi_q, 32'hBB);
    chk("no_err_yet", {31'b0, err}, 32'h0);

    // Async reset mid-flight (count 2), MFHI stalled.
    mult_start = 1'b1;
    cyc();
    cyc();
    mult_start = 1'b0;
    mfhi_req   = 1'b1;
    #1;
    chk("pre_rst_stall", {31'b0, stall}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_hi", hi_q, 32'h0);
    chk("mid_rst_lo", lo_q, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_stall", {31'b0, stall}, 32'h0);
    chk("mid_rst_rd", rd_data, 32'h0);
    chk("mid_rst_err", {31'b0, err}, 32'h0);
    idle();
    #1;
    rst = 1'b1;
    cyc();

    // Done with nothing in flight.
    done(32'h6, 32'h5);
    cyc();
    idle();
    chk("undf_err", {31'b0, err}, 32'h1);
    chk("undf_hi", hi_q, 32'h6);
    chk("undf_lo", lo_q, 32'h5);
    chk("undf_busy", {31'b0, busy}, 32'h0);
    cyc();
    cyc();
    chk("undf_sticky", {31'b0, err}, 32'h1);

    // Five starts: count must hold at four.
    do_reset();
    mult_start = 1'b1;
    repeat (5) cyc();
    idle();
    chk("ovf_err", {31'b0, err}, 32'h1);
    chk("ovf_busy", {31'b0, busy}, 32'h1);
    done(32'h0, 32'h1);
    cyc();
    cyc();
    cyc();
    #1;
    chk("ovf_busy_last", {31'b0, busy}, 32'h1);
    cyc();
    idle();
    chk("ovf_idle", {31'b0, busy}, 32'h0);
    chk("ovf_sticky", {31'b0, err}, 32'h1);

    // MFHI and MFLO together: HI wins, err set.
    do_reset();
    mthi_en = 1'b1;
    mtlo_en = 1'b1;
    mt_data = 32'h12;
    cyc();
    idle();
    mtlo_en = 1'b1;
    mt_data = 32'h34;
    cyc();
    idle();
    chk("cf_pre_err", {31'b0, err}, 32'h0);
    mfhi_req = 1'b1;
    mflo_req = 1'b1;
    push("cf_rd_hi", 32'h12);
    cyc();
    idle();
    chk("cf_err", {31'b0, err}, 32'h1);
    chk("cf_lo", lo_q, 32'h34);

    cyc();
    chk("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
